// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle and error-status signals for logic_unit_pipe.
// The master side is the operand source plus result consumer; the slave side is the unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             inj_fault;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic             clr_err;

    modport master (
        output in_valid, a, b, op, inj_fault, out_ready, clr_err,
        input  in_ready, out_valid, s, mismatch, err_sticky, err_count
    );

    modport slave (
        input  in_valid, a, b, op, inj_fault, out_ready, clr_err,
        output in_ready, out_valid, s, mismatch, err_sticky, err_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise gate unit: each result is computed directly and again in De Morgan
// form, and the two are compared to flag and count disagreements seen by the consumer.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_unit_pipe_if.slave bus
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] direct_gate(input logic [2:0] f_op,
                                                     input logic [WIDTH-1:0] f_a,
                                                     input logic [WIDTH-1:0] f_b);
        logic [WIDTH-1:0] r;
        case (f_op)
            OP_AND:  r = f_a & f_b;
            OP_NAND: r = ~(f_a & f_b);
            OP_OR:   r = f_a | f_b;
            OP_NOR:  r = ~(f_a | f_b);
            OP_XOR:  r = f_a ^ f_b;
            OP_XNOR: r = ~(f_a ^ f_b);
            OP_NOT:  r = ~f_a;
            default: r = f_a;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] dm_or(input logic [WIDTH-1:0] f_x,
                                               input logic [WIDTH-1:0] f_y);
        return ~(~f_x & ~f_y);
    endfunction

    function automatic logic [WIDTH-1:0] dm_and(input logic [WIDTH-1:0] f_x,
                                                input logic [WIDTH-1:0] f_y);
        return ~(~f_x | ~f_y);
    endfunction

    // Built only from NOT plus OR/AND; the fault hook flips bit 0 of this path alone.
    function automatic logic [WIDTH-1:0] demorgan_gate(input logic [2:0] f_op,
                                                       input logic [WIDTH-1:0] f_a,
                                                       input logic [WIDTH-1:0] f_b,
                                                       input logic f_inj);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] m;
        case (f_op)
            OP_AND:  r = ~(~f_a | ~f_b);
            OP_NAND: r = ~f_a | ~f_b;
            OP_OR:   r = ~(~f_a & ~f_b);
            OP_NOR:  r = ~f_a & ~f_b;
            OP_XOR:  r = dm_or(f_a, f_b) & ~dm_and(f_a, f_b);
            OP_XNOR: r = ~(dm_or(f_a, f_b) & ~dm_and(f_a, f_b));
            OP_NOT:  r = ~f_a;
            default: r = f_a;
        endcase
        m    = W_ZERO;
        m[0] = f_inj;
        return r ^ m;
    endfunction

    logic             r_v1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [2:0]       r_op1;
    logic             r_inj1;
    logic             r_v2;
    logic [WIDTH-1:0] r_s2;
    logic             r_mis2;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_count;

    logic             w_en1;
    logic             w_en2;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_direct;
    logic [WIDTH-1:0] w_dm;

    assign w_en2    = ~r_v2 | bus.out_ready;
    assign w_en1    = ~r_v1 | w_en2;
    assign w_in_hs  = bus.in_valid & w_en1;
    assign w_out_hs = r_v2 & bus.out_ready;
    assign w_direct = direct_gate(r_op1, r_a1, r_b1);
    assign w_dm     = demorgan_gate(r_op1, r_a1, r_b1, r_inj1);

    assign bus.in_ready   = w_en1;
    assign bus.out_valid  = r_v2;
    assign bus.s          = r_s2;
    assign bus.mismatch   = r_mis2;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;

    // Stage 1: capture operands on an input handshake, otherwise take a bubble or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_a1   <= W_ZERO;
            r_b1   <= W_ZERO;
            r_op1  <= 3'd0;
            r_inj1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= w_in_hs;
            if (w_in_hs) begin
                r_a1   <= bus.a;
                r_b1   <= bus.b;
                r_op1  <= bus.op;
                r_inj1 <= bus.inj_fault;
            end else begin
                r_inj1 <= 1'b0;
            end
        end else begin
            r_v1 <= r_v1;
        end
    end

    // Stage 2: register the direct result and path comparison; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_s2   <= W_ZERO;
            r_mis2 <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2   <= w_direct;
                r_mis2 <= (w_direct != w_dm);
            end else begin
                r_mis2 <= 1'b0;
            end
        end else begin
            r_v2 <= r_v2;
        end
    end

    // Error accounting counts a mismatch once, when it is handed over; a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= CNT_ZERO;
        end else if (bus.clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= CNT_ZERO;
        end else if (w_out_hs && r_mis2) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + CNT_ONE;
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_err_sticky <= r_err_sticky;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe: an 8-bit instance and a 1-bit,
// 2-bit-counter instance, both scored against a truth-table model with a result queue.
module tb_logic_unit_pipe;
    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
    logic_unit_pipe_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    logic_unit_pipe #(.WIDTH(1), .CNT_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       m_sticky0 = 1'b0;
    logic       m_sticky1 = 1'b0;
    logic [7:0] m_cnt0    = 8'd0;
    logic [1:0] m_cnt1    = 2'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gate truth expressed with plain operators from the function table.
    function automatic logic [7:0] ref_gate(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic monitor0();
        logic [8:0] e;
        if (!rst_n) begin
            q0.delete();
            m_sticky0 = 1'b0;
            m_cnt0    = 8'd0;
            return;
        end
        check_eq("err_sticky0", bus0.err_sticky, m_sticky0);
        check_eq("err_count0", bus0.err_count, m_cnt0);
        if (bus0.out_valid && bus0.out_ready) begin
            check_eq("out_expected0", q0.size() > 0, 1'b1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_eq("s0", bus0.s, e[7:0]);
                check_eq("mismatch0", bus0.mismatch, e[8]);
                if (e[8]) begin
                    m_sticky0 = 1'b1;
                    if (m_cnt0 != 8'hFF) m_cnt0 = m_cnt0 + 8'd1;
                end
            end
        end
        if (bus0.clr_err) begin
            m_sticky0 = 1'b0;
            m_cnt0    = 8'd0;
        end
        if (bus0.in_valid && bus0.in_ready)
            q0.push_back({bus0.inj_fault, ref_gate(bus0.op, bus0.a, bus0.b)});
    endtask

    task automatic monitor1();
        logic [8:0] e;
        if (!rst_n) begin
            q1.delete();
            m_sticky1 = 1'b0;
            m_cnt1    = 2'd0;
            return;
        end
        check_eq("err_sticky1", bus1.err_sticky, m_sticky1);
        check_eq("err_count1", bus1.err_count, m_cnt1);
        if (bus1.out_valid && bus1.out_ready) begin
            check_eq("out_expected1", q1.size() > 0, 1'b1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_eq("s1", bus1.s, e[7:0]);
                check_eq("mismatch1", bus1.mismatch, e[8]);
                if (e[8]) begin
                    m_sticky1 = 1'b1;
                    if (m_cnt1 != 2'd3) m_cnt1 = m_cnt1 + 2'd1;
                end
            end
        end
        if (bus1.clr_err) begin
            m_sticky1 = 1'b0;
            m_cnt1    = 2'd0;
        end
        if (bus1.in_valid && bus1.in_ready)
            q1.push_back({bus1.inj_fault,
                          ref_gate(bus1.op, {7'd0, bus1.a}, {7'd0, bus1.b}) & 8'h01});
    endtask

    // Score both instances mid-cycle, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor0();
        monitor1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tbl [8];
        logic [7:0] s_hold;
        logic       hs;
        int         acc;
        int         n;

        tbl = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = 8'd0; bus0.b = 8'd0; bus0.op = 3'd0;
        bus0.inj_fault = 1'b0; bus0.out_ready = 1'b1; bus0.clr_err = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.op = 3'd0;
        bus1.inj_fault = 1'b0; bus1.out_ready = 1'b1; bus1.clr_err = 1'b0;

        #12;
        check_eq("rst_out_valid", bus0.out_valid, 1'b0);
        check_eq("rst_s", bus0.s, 8'h00);
        check_eq("rst_mismatch", bus0.mismatch, 1'b0);
        check_eq("rst_in_ready", bus0.in_ready, 1'b1);
        check_eq("rst_err_count", bus0.err_count, 8'h00);
        check_eq("rst_err_sticky", bus0.err_sticky, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: all eight ops back to back, no backpressure.
        for (int t = 1; t <= 10; t++) begin
            if (t <= 8) begin
                bus0.in_valid = 1'b1; bus0.a = 8'hF0; bus0.b = 8'h3C; bus0.op = 3'(t - 1);
            end else begin
                bus0.in_valid = 1'b0;
            end
            tick();
            if (t == 1) check_eq("lat_first_bubble", bus0.out_valid, 1'b0);
            if (t >= 2 && t <= 9) begin
                check_eq("dir_valid", bus0.out_valid, 1'b1);
                check_eq("dir_s", bus0.s, tbl[t-2]);
                check_eq("dir_mismatch", bus0.mismatch, 1'b0);
            end
        end

        // Exhaustive 1-bit: every op against every operand pair.
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                bus1.in_valid = 1'b1; bus1.op = 3'(op);
                bus1.a = ab[1]; bus1.b = ab[0];
                tick();
            end
        end
        bus1.in_valid = 1'b0;
        repeat (3) tick();
        check_eq("exh_err_count", bus1.err_count, 2'd0);
        check_eq("exh_drained", q1.size(), 0);

        // Backpressure: two accepts fill the pipe, the third waits.
        bus0.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus0.in_valid = 1'b1;
            bus0.a = 8'($urandom); bus0.b = 8'($urandom); bus0.op = 3'($urandom);
            hs = bus0.in_valid & bus0.in_ready;
            tick();
            if (hs) acc++;
        end
        check_eq("bp_accepts", acc, 2);
        check_eq("bp_in_ready", bus0.in_ready, 1'b0);
        check_eq("bp_out_valid", bus0.out_valid, 1'b1);
        s_hold = bus0.s;
        repeat (3) begin
            tick();
            check_eq("bp_s_stable", bus0.s, s_hold);
            check_eq("bp_held_valid", bus0.out_valid, 1'b1);
        end
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            hs = bus0.in_valid & bus0.in_ready;
            tick();
            if (hs) acc++;
        end
        check_eq("bp_third_accept", acc, 3);
        bus0.in_valid = 1'b0;
        repeat (4) tick();
        check_eq("bp_drained", q0.size(), 0);

        // Fault injection on NAND(FF,FF), held for five cycles before the handshake.
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1; bus0.op = 3'd1; bus0.a = 8'hFF; bus0.b = 8'hFF;
        bus0.inj_fault = 1'b1;
        check_eq("flt_in_ready", bus0.in_ready, 1'b1);
        tick();
        bus0.in_valid = 1'b0; bus0.inj_fault = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 5) begin
            tick();
            n++;
        end
        check_eq("flt_out_valid", bus0.out_valid, 1'b1);
        check_eq("flt_s", bus0.s, 8'h00);
        check_eq("flt_mismatch", bus0.mismatch, 1'b1);
        repeat (5) tick();
        check_eq("flt_stall_count", bus0.err_count, 8'd0);
        bus0.out_ready = 1'b1;
        tick();
        check_eq("flt_sticky", bus0.err_sticky, 1'b1);
        check_eq("flt_count", bus0.err_count, 8'd1);
        repeat (3) tick();
        check_eq("flt_count_once", bus0.err_count, 8'd1);

        // Saturation with a 2-bit counter, then a clear coinciding with a counting handshake.
        for (int k = 0; k < 5; k++) begin
            bus1.in_valid = 1'b1; bus1.op = 3'd1; bus1.a = 1'b1; bus1.b = 1'b1;
            bus1.inj_fault = 1'b1;
            tick();
        end
        bus1.in_valid = 1'b0; bus1.inj_fault = 1'b0;
        repeat (3) tick();
        check_eq("sat_count", bus1.err_count, 2'd3);
        check_eq("sat_sticky", bus1.err_sticky, 1'b1);
        bus1.in_valid = 1'b1; bus1.inj_fault = 1'b1;
        tick();
        bus1.in_valid = 1'b0; bus1.inj_fault = 1'b0;
        tick();
        check_eq("clr_out_valid", bus1.out_valid, 1'b1);
        check_eq("clr_mismatch", bus1.mismatch, 1'b1);
        bus1.clr_err = 1'b1;
        tick();
        bus1.clr_err = 1'b0;
        check_eq("clr_count", bus1.err_count, 2'd0);
        check_eq("clr_sticky", bus1.err_sticky, 1'b0);

        // Asynchronous reset with both stages of the 8-bit unit full.
        bus0.out_ready = 1'b0;
        repeat (2) begin
            bus0.in_valid = 1'b1; bus0.a = 8'($urandom); bus0.b = 8'($urandom);
            bus0.op = 3'($urandom);
            tick();
        end
        bus0.in_valid = 1'b0;
        check_eq("ar_full", bus0.out_valid, 1'b1);
        check_eq("ar_full_ready", bus0.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_out_valid", bus0.out_valid, 1'b0);
        check_eq("ar_in_ready", bus0.in_ready, 1'b1);
        check_eq("ar_count", bus0.err_count, 8'd0);
        check_eq("ar_sticky", bus0.err_sticky, 1'b0);
        check_eq("ar_s", bus0.s, 8'h00);
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        bus0.in_valid = 1'b1; bus0.a = 8'($urandom); bus0.b = 8'($urandom);
        bus0.op = 3'($urandom);
        tick();
        bus0.in_valid = 1'b0;
        n = 1;
        while (!bus0.out_valid && n < 6) begin
            tick();
            n++;
        end
        check_eq("ar_latency", n, 2);

        // Random traffic on both instances with backpressure, faults and clears.
        for (int c = 0; c < 400; c++) begin
            bus0.in_valid  = ($urandom_range(0, 3) != 0);
            bus0.a         = 8'($urandom);
            bus0.b         = 8'($urandom);
            bus0.op        = 3'($urandom);
            bus0.inj_fault = ($urandom_range(0, 7) == 0);
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            bus0.clr_err   = ($urandom_range(0, 31) == 0);
            bus1.in_valid  = ($urandom_range(0, 3) != 0);
            bus1.a         = 1'($urandom);
            bus1.b         = 1'($urandom);
            bus1.op        = 3'($urandom);
            bus1.inj_fault = ($urandom_range(0, 3) == 0);
            bus1.out_ready = ($urandom_range(0, 2) != 0);
            bus1.clr_err   = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.clr_err = 1'b0; bus0.inj_fault = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.clr_err = 1'b0; bus1.inj_fault = 1'b0;
        repeat (5) tick();
        check_eq("rand_drained0", q0.size(), 0);
        check_eq("rand_drained1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
